// File: rtl/uart_tx_fifo.sv
// UART transmitter with a word FIFO in front of it.
// Frames are start, LSB-first data, optional parity, then stop bits.
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int BAUD_DIV    = 868,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          UART_TX
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Parity over the payload bits only; odd mode inverts the even result.
  function automatic logic parity_f(input logic [7:0] word);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < DATA_BITS) p = p ^ word[i];
      else               p = p;
    end
    if (PARITY_MODE == 2) p = ~p;
    else                  p = p;
    return p;
  endfunction

  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [2:0]    state_r;
  logic [BW-1:0] baud_r;
  logic [2:0]    bit_r;
  logic [7:0]    shift_r;
  logic          par_r;
  logic          tx_r;
  logic          push_s, pop_s, bit_end_s, frame_end_s, line_s;

  assign tx_ready    = (count_r < DEPTH_C);
  assign push_s      = tx_valid & tx_ready;
  assign bit_end_s   = (baud_r == BAUD_LAST);
  assign frame_end_s = (state_r == ST_STOP) && bit_end_s && (bit_r == STOP_LAST);
  // A word leaves the FIFO either from idle or exactly at the end of a frame.
  assign pop_s       = (count_r != {CW{1'b0}}) && ((state_r == ST_IDLE) || frame_end_s);
  assign busy        = (state_r != ST_IDLE) || (count_r != {CW{1'b0}});
  assign fifo_count  = count_r;
  assign UART_TX     = tx_r;

  // FIFO storage write port.
  always_ff @(posedge sysclk) begin
    if (push_s) mem_r[wr_ptr_r] <= tx_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Shift register and parity bit captured from the popped word.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      shift_r <= 8'h00;
      par_r   <= 1'b0;
    end else if (pop_s) begin
      shift_r <= mem_r[rd_ptr_r];
      par_r   <= parity_f(mem_r[rd_ptr_r]);
    end else if ((state_r == ST_DATA) && bit_end_s) begin
      shift_r <= {1'b0, shift_r[7:1]};
    end
  end

  // Frame sequencer with baud and bit counters.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      baud_r  <= {BW{1'b0}};
      bit_r   <= 3'd0;
    end else begin
      if (state_r == ST_IDLE || bit_end_s) baud_r <= {BW{1'b0}};
      else                                 baud_r <= baud_r + 1'b1;
      case (state_r)
        ST_IDLE: begin
          if (pop_s) state_r <= ST_START;
        end
        ST_START: begin
          if (bit_end_s) begin
            state_r <= ST_DATA;
            bit_r   <= 3'd0;
          end
        end
        ST_DATA: begin
          if (bit_end_s) begin
            if (bit_r == DATA_LAST) begin
              bit_r   <= 3'd0;
              state_r <= (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
            end else begin
              bit_r <= bit_r + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_end_s) begin
            state_r <= ST_STOP;
            bit_r   <= 3'd0;
          end
        end
        ST_STOP: begin
          if (bit_end_s) begin
            if (bit_r == STOP_LAST) begin
              bit_r   <= 3'd0;
              state_r <= pop_s ? ST_START : ST_IDLE;
            end else begin
              bit_r <= bit_r + 1'b1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          bit_r   <= 3'd0;
        end
      endcase
    end
  end

  // Line level for the current state, registered one cycle later.
  always_comb begin
    line_s = 1'b1;
    case (state_r)
      ST_IDLE:   line_s = 1'b1;
      ST_START:  line_s = 1'b0;
      ST_DATA:   line_s = shift_r[0];
      ST_PARITY: line_s = par_r;
      ST_STOP:   line_s = 1'b1;
      default:   line_s = 1'b1;
    endcase
  end

  // Registered serial output.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) tx_r <= 1'b1;
    else        tx_r <= line_s;
  end

endmodule
